// File: rtl/alu_seq_if.sv
// Operand-issue / result-consumer bundle for alu_seq.
// The DUT takes the slave side; the issuing stage or bench takes the master side.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         sel_op;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] out_result;
  logic               out_valid;
  logic               out_ready;
  logic               out_zero;
  logic               out_div0;

  modport master (
    output a, b, sel_op, in_valid, out_ready,
    input  in_ready, out_result, out_valid, out_zero, out_div0
  );

  modport slave (
    input  a, b, sel_op, in_valid, out_ready,
    output in_ready, out_result, out_valid, out_zero, out_div0
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked 16-op ALU, WIDTH-bit unsigned operands, 2*WIDTH-bit result.
// Multiply (shift-add) and divide (restoring) share one iterative engine.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_m;
  logic             is_div;
  logic [RW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    result;
  logic             zero, div0;
  logic             iter_op, div_by0;
  logic [WIDTH-1:0] lo_res;
  logic [RW-1:0]    single_res, step_acc;
  logic [WIDTH:0]   mul_sum, div_tmp, div_diff;

  assign div_by0 = (bus.sel_op == 4'h4) && (bus.b == '0);
  assign iter_op = (bus.sel_op == 4'h3) || ((bus.sel_op == 4'h4) && (bus.b != '0));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = iter_op ? BUSY : DONE;
      BUSY:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    bus.in_ready  = (state == IDLE) && !rst;
    bus.out_valid = (state == DONE);
  end

  // Single-cycle results; ops producing only WIDTH bits go through lo_res,
  // so the zero-extension happens after inversion. Mul/div leave this 0,
  // which is also the required divide-by-zero result.
  always_comb begin
    lo_res     = '0;
    single_res = '0;
    case (bus.sel_op)
      4'h0: lo_res[0]  = (bus.a == bus.b);
      4'h1: single_res = {{(WIDTH-1){1'b0}}, {1'b0, bus.a} + {1'b0, bus.b}};
      4'h2: single_res = {{WIDTH{1'b0}}, bus.a} - {{WIDTH{1'b0}}, bus.b};
      4'h5: single_res = {{(WIDTH-1){1'b0}}, bus.a, 1'b0};
      4'h6: lo_res     = bus.a >> 1;
      4'h7: lo_res     = bus.a & bus.b;
      4'h8: lo_res     = bus.a | bus.b;
      4'h9: lo_res     = bus.a ^ bus.b;
      4'hA: lo_res     = ~(bus.a | bus.b);
      4'hB: lo_res     = ~(bus.a & bus.b);
      4'hC: lo_res     = ~(bus.a ^ bus.b);
      4'hD: lo_res     = ~bus.b;
      4'hE: lo_res[0]  = (bus.a > bus.b);
      4'hF: lo_res[0]  = (bus.a < bus.b);
      default: ;
    endcase
    single_res = single_res | {{WIDTH{1'b0}}, lo_res};
  end

  // One engine step. acc = {upper, lower}: multiply keeps the partial
  // product in upper and the shifting multiplier in lower; divide keeps the
  // partial remainder in upper and dividend/quotient bits in lower.
  always_comb begin
    mul_sum  = {1'b0, acc[RW-1:WIDTH]} + (acc[0] ? {1'b0, op_m} : '0);
    div_tmp  = {acc[RW-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_tmp - {1'b0, op_m};
    if (is_div)
      step_acc = div_diff[WIDTH] ? {div_tmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      step_acc = {mul_sum, acc[WIDTH-1:1]};
  end

  // Datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_m   <= '0;
      is_div <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          is_div <= (bus.sel_op == 4'h4);
          op_m   <= (bus.sel_op == 4'h4) ? bus.b : bus.a;
          acc    <= {{WIDTH{1'b0}}, (bus.sel_op == 4'h4) ? bus.a : bus.b};
          div0   <= div_by0;
          if (iter_op) begin
            cnt <= CW'(WIDTH);
          end else begin
            result <= single_res;
            zero   <= (single_res == '0);
          end
        end
        BUSY: begin
          acc <= step_acc;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= step_acc;
            zero   <= (step_acc == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_result = result;
  assign bus.out_zero   = zero;
  assign bus.out_div0   = div0;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 4-bit-opcode combinational ALU. It keeps the same 16-entry opcode map, generalised to WIDTH-bit operands with a 2*WIDTH-bit result. Multiply and divide run on a shared iterative shift engine, and divide also returns the remainder. The block sits between an operand-issue stage and a result consumer, using valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, operand width; must be >= 2; result width RW = 2*WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- sel_op  input  4  opcode
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  block can accept an operation
- out_result  output  RW  registered result
- out_valid  output  1  out_result and flags are valid
- out_ready  input  1  consumer accepts the result
- out_zero  output  1  out_result == 0
- out_div0  output  1  divide was attempted with b == 0

## Operation
- Opcodes, all unsigned. Results are zero-extended to RW unless stated otherwise.
  - 0000: a==b.
  - 0001: a+b, with carry in bit WIDTH.
  - 0010: (a-b) mod 2^RW.
  - 0011: a*b, iterative.
  - 0100: {a%b, a/b}, iterative. Remainder goes in the upper WIDTH bits, quotient in the lower WIDTH bits.
  - 0101: a<<1, with a's MSB kept in bit WIDTH.
  - 0110: a>>1.
  - 0111 through 1100: AND, OR, XOR, NOR, NAND, XNOR. Each is computed on WIDTH bits, then zero-extended.
  - 1101: ~b, computed on WIDTH bits, then zero-extended.
  - 1110: a>b.
  - 1111: a<b.
- Compare results are 1 or 0 in bit 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, capture a, b and sel_op.
    - Single-cycle op: register the result and go to DONE.
    - 0011, or 0100 with b!=0: load the engine, set the counter to WIDTH, go to BUSY.
    - 0100 with b==0: register out_result=0 and out_div0=1, go to DONE.
  - BUSY: in_ready=0. Perform one shift-add (multiply) or one restoring-subtract step (divide) per cycle and decrement the counter. On the cycle the counter reaches 0, write the result register and go to DONE.
  - DONE: out_valid=1, in_ready=0. out_result, out_zero and out_div0 are held stable until out_ready=1. Then go to IDLE.
- out_zero is computed from the value written to the result register and updates together with it.
- out_div0 is cleared on every accepted operation other than a divide by zero.
- Inputs are sampled only on the accept cycle. Changes to a, b or sel_op at any other time have no effect.
- in_valid while in_ready=0 is ignored. Upstream must hold it.

## Timing
- Reset values:
  - in_ready=1 on the first cycle after rst deasserts. It is 0 while rst is high.
  - out_valid=0, out_result=0, out_zero=0, out_div0=0.
  - State = IDLE, counter = 0.
- rst has priority in every state. Asserting it mid-BUSY or in DONE aborts the operation, and the result is lost.
- Latency is measured from the accept edge (cycle 0: in_valid and in_ready both high).
  - Single-cycle ops and divide-by-zero: out_valid=1 at cycle 1.
  - Multiply and divide with b!=0: out_valid=1 at cycle WIDTH+1.
- Release:
  - If out_ready=1 on the first out_valid cycle, out_valid drops and in_ready rises at the next cycle.
  - The best-case issue interval is 2 cycles for single-cycle ops and WIDTH+2 cycles for iterative ops.
- out_ready while out_valid=0 is ignored.
- Back-pressure: with out_ready held low, DONE persists indefinitely and all outputs stay constant.
- Boundary rules:
  - The counter never wraps; it is loaded only from IDLE.
  - Multiply: a or b = 0 gives 0 after the full WIDTH cycles; there is no early exit.
  - Divide: a < b gives quotient 0 and remainder a.

## Test plan
- Reset, WIDTH=8: hold rst for 3 cycles with in_valid=1. Required: in_ready=0 and out_valid=0 throughout; on release, in_ready=1, out_result=0 and all flags 0, and no operation was accepted.
- Single-cycle ops, WIDTH=8, out_ready=1:
  - sub a=3, b=5 -> out_result=0xFFFE at cycle 1.
  - add a=0xFF, b=0x01 -> 0x0100.
  - NOR a=0x0F, b=0xF0 -> 0x0000 with out_zero=1.
  - op 1111 a=2, b=9 -> 0x0001.
- Multiply, WIDTH=8: a=0xFF, b=0xFF -> out_result=0xFE01 with out_valid first high at cycle 9. in_ready=0 during cycles 1 through 9. A pulse of in_valid with new operands during BUSY is ignored.
- Divide, WIDTH=8:
  - a=200, b=7 -> 0x041C at cycle 9, out_div0=0.
  - a=3, b=10 -> 0x0300.
  - a=5, b=0 -> 0x0000, out_div0=1, out_zero=1 at cycle 1. The next add 1+1 -> out_div0=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid rises. out_result and the flags are unchanged and in_ready stays 0. One cycle after out_ready=1, in_ready=1.
- Reset mid-operation: assert rst at cycle 4 of a divide. Required: next cycle out_valid=0 and out_result=0; after release, a fresh add 2+2 returns 0x0004 at cycle 1.
